// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: FSM state encodings, ALU_OP_* codes and mul/div op decode helpers shared by muldiv_seq and its bench
package muldiv_seq_pkg;
  typedef enum logic [2:0] {
    MD_ST_IDLE = 3'd0,
    MD_ST_PREP = 3'd1,
    MD_ST_CALC = 3'd2,
    MD_ST_FIX  = 3'd3,
    MD_ST_DONE = 3'd4
  } md_state_t;
  localparam logic [5:0] ALU_OP_ADD  = 6'h00;
  localparam logic [5:0] ALU_OP_SUB  = 6'h01;
  localparam logic [5:0] ALU_OP_MUL  = 6'h18;
  localparam logic [5:0] ALU_OP_MUH  = 6'h19;
  localparam logic [5:0] ALU_OP_MULU = 6'h1a;
  localparam logic [5:0] ALU_OP_MUHU = 6'h1b;
  localparam logic [5:0] ALU_OP_DIV  = 6'h1c;
  localparam logic [5:0] ALU_OP_MOD  = 6'h1d;
  localparam logic [5:0] ALU_OP_DIVU = 6'h1e;
  localparam logic [5:0] ALU_OP_MODU = 6'h1f;
  localparam int OPB_DIV = 2;
  localparam int OPB_UNS = 1;
  localparam int OPB_HI  = 0;
  function automatic logic op_is_muldiv(input logic [5:0] op);
    return op[5:3] == 3'b011;
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add multiply (mode=0) or restoring divide (mode=1) iteration on {hi,lo} with operand
module muldiv_step import muldiv_seq_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);
  logic [WIDTH:0] sum, rem, diff;
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    rem  = {hi, lo[WIDTH-1]};
    diff = rem - {1'b0, operand};
    hi_n = mode ? (diff[WIDTH] ? rem[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    lo_n = mode ? {lo[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MUL/MUH/MULU/MUHU/DIV/MOD/DIVU/MODU sequencer (start/op/a/b/flush in; ready/busy/done/result/div_zero out); MULDIV_FAST_MUL_EN enables single-cycle multiply
module muldiv_seq import muldiv_seq_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  md_state_t state, state_n;
  logic [2:0] op_r;
  logic [WIDTH-1:0] a_r, b_r, hi, lo, hi_n, lo_n, a_mag, b_mag, fix_hi, fix_res;
  logic [2*WIDTH-1:0] prod_f;
  logic [CW-1:0] cnt;
  logic neg_q, neg_r, dz, accept, is_div, sa, sb, b_zero, fast_mul;
  assign accept  = state == MD_ST_IDLE && start && !flush && op_is_muldiv(op);
  assign is_div  = op_r[OPB_DIV];
  assign b_zero  = b_r == '0;
  assign sa      = !op_r[OPB_UNS] && a_r[WIDTH-1];
  assign sb      = !op_r[OPB_UNS] && b_r[WIDTH-1];
  assign a_mag   = sa ? -a_r : a_r;
  assign b_mag   = sb ? -b_r : b_r;
  // low half of the negated product doubles as the negated quotient
  assign prod_f  = neg_q ? -{hi, lo} : {hi, lo};
  assign fix_hi  = is_div ? (neg_r ? -hi : hi) : prod_f[2*WIDTH-1:WIDTH];
  assign fix_res = op_r[OPB_HI] ? fix_hi : prod_f[WIDTH-1:0];
`ifdef MULDIV_FAST_MUL_EN
  assign fast_mul = !is_div;
`else
  assign fast_mul = 1'b0;
`endif
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode(is_div),
    .hi(hi),
    .lo(lo),
    .operand(b_r),
    .hi_n(hi_n),
    .lo_n(lo_n)
  );
  always_ff @(posedge clk)
    state <= rst ? MD_ST_IDLE : state_n;
  always_comb begin
    state_n = MD_ST_IDLE;
    case (state)
      MD_ST_IDLE: state_n = accept ? MD_ST_PREP : MD_ST_IDLE;
      MD_ST_PREP: state_n = flush ? MD_ST_IDLE : (is_div && b_zero) ? MD_ST_DONE : fast_mul ? MD_ST_FIX : MD_ST_CALC;
      MD_ST_CALC: state_n = flush ? MD_ST_IDLE : cnt == '0 ? MD_ST_FIX : MD_ST_CALC;
      MD_ST_FIX:  state_n = flush ? MD_ST_IDLE : MD_ST_DONE;
      default:    state_n = MD_ST_IDLE;
    endcase
  end
  always_comb begin
    ready    = state == MD_ST_IDLE;
    busy     = state inside {MD_ST_PREP, MD_ST_CALC, MD_ST_FIX};
    done     = state == MD_ST_DONE;
    div_zero = done && dz;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      result <= '0;
    end else begin
      if (accept) begin
        op_r <= op[2:0];
        a_r  <= a;
        b_r  <= b;
      end
      if (state == MD_ST_PREP) begin
        b_r   <= b_mag;
        hi    <= '0;
        lo    <= a_mag;
        cnt   <= CW'(WIDTH - 1);
        neg_q <= sa ^ sb;
        neg_r <= sa;
        dz    <= is_div && b_zero;
`ifdef MULDIV_FAST_MUL_EN
        if (!is_div) {hi, lo} <= (2*WIDTH)'(a_mag) * (2*WIDTH)'(b_mag);
`endif
        // divide by zero: quotient all-ones, remainder the raw dividend
        if (is_div && b_zero && !flush) result <= op_r[OPB_HI] ? a_r : '1;
      end
      if (state == MD_ST_CALC) begin
        hi  <= hi_n;
        lo  <= lo_n;
        cnt <= cnt - CW'(1);
      end
      if (state == MD_ST_FIX && !flush) result <= fix_res;
    end
  end
endmodule
